// File: rtl/output_display_pkg.sv
// Shared definitions for the output display path: widths, segment encoding and FSM states.
package output_display_pkg;

    localparam int DATA_W  = 18;
    localparam int NUM_DIG = 6;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low gfedcba patterns, index = decimal digit (entry 9 is leftmost).
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        UPDATE
    } state_t;

endpackage

// File: rtl/output_display_bcd_to_7seg.sv
// Combinational BCD nibble to active-low 7-segment pattern; non-decimal nibbles go dark.
module bcd_to_7seg
    import output_display_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (digit_i <= 4'd9) begin
            seg_o = SEG_TABLE[digit_i];
        end
    end

endmodule

// File: rtl/output_display.sv
// Latches a register value, converts it to decimal with a sequential double-dabble and
// drives LEDs plus six 7-segment displays; haltOut stalls the processor for DATA_W+1 cycles.
module output_display #(
    parameter int DATA_W      = output_display_pkg::DATA_W,
    parameter int NUM_DIG     = output_display_pkg::NUM_DIG,
    parameter int BLANK_ZEROS = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   escreveOutput,
    input  logic [DATA_W-1:0]      dado,
    output logic                   haltOut,
    output logic [DATA_W-1:0]      leds,
    output logic [7*NUM_DIG-1:0]   hex
);
    import output_display_pkg::*;

    localparam int BCD_W = 4 * NUM_DIG;
    localparam int CNT_W = $clog2(DATA_W);

    state_t               state_q;
    logic [DATA_W-1:0]    bin_q;
    logic [DATA_W-1:0]    val_q;
    logic [DATA_W-1:0]    leds_q;
    logic [BCD_W-1:0]     bcd_q;
    logic [BCD_W-1:0]     bcd_adj;
    logic [CNT_W-1:0]     cnt_q;
    logic [7*NUM_DIG-1:0] hex_q;
    logic [7*NUM_DIG-1:0] hex_d;
    logic                 halt_q;
    logic                 lead_zero;
    logic [6:0]           seg_w [NUM_DIG];

    // Per-nibble add-3 correction; nibbles never carry into each other.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    for (genvar g = 0; g < NUM_DIG; g++) begin : g_seg
        bcd_to_7seg u_seg (
            .digit_i (bcd_q[4*g +: 4]),
            .seg_o   (seg_w[g])
        );
    end

    // Walk from the most significant digit down; stay blank while everything above is zero.
    always_comb begin
        lead_zero = 1'b1;
        hex_d     = '0;
        for (int i = NUM_DIG - 1; i >= 0; i--) begin
            lead_zero = lead_zero && (bcd_q[4*i +: 4] == 4'd0);
            if (i != 0 && BLANK_ZEROS != 0 && lead_zero) begin
                hex_d[7*i +: 7] = SEG_BLANK;
            end else begin
                hex_d[7*i +: 7] = seg_w[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            val_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            leds_q  <= '0;
            hex_q   <= {NUM_DIG{SEG_BLANK}};
            halt_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (escreveOutput) begin
                        bin_q   <= dado;
                        val_q   <= dado;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        halt_q  <= 1'b1;
                        state_q <= CONVERT;
                    end
                end
                CONVERT: begin
                    {bcd_q, bin_q} <= {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
                    cnt_q          <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_q <= UPDATE;
                    end
                end
                UPDATE: begin
                    hex_q   <= hex_d;
                    leds_q  <= val_q;
                    halt_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign haltOut = halt_q;
    assign leds    = leds_q;
    assign hex     = hex_q;

endmodule

// File: tb/tb_output_display.sv
// Scoreboard bench for output_display: driver queues expected displays, monitor checks each conversion.
module tb_output_display;

    logic        clock = 1'b0;
    logic        reset;
    logic        escreveOutput;
    logic [17:0] dado;
    logic        haltOut;
    logic [17:0] leds;
    logic [41:0] hex;

    output_display #(
        .DATA_W      (18),
        .NUM_DIG     (6),
        .BLANK_ZEROS (1)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .escreveOutput (escreveOutput),
        .dado          (dado),
        .haltOut       (haltOut),
        .leds          (leds),
        .hex           (hex)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [41:0] hex;
        logic [17:0] leds;
        int          len;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pushed = 0;
    int   n_conv   = 0;
    bit   mon_en   = 1'b0;

    logic        m_prev = 1'b0;
    int          m_len  = 0;
    bit          m_stable = 1'b1;
    logic [41:0] m_pre_hex;
    logic [17:0] m_pre_leds;
    exp_t        m_e;

    localparam logic [41:0] ALL_BLANK = {6{7'h7F}};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Decimal digits by division; anything above the most significant nonzero digit is dark.
    function automatic logic [41:0] model_hex(input int v);
        int digs[6];
        int msd = 0;
        int t   = v;
        logic [41:0] r = '0;
        for (int i = 0; i < 6; i++) begin
            digs[i] = t % 10;
            t = t / 10;
            if (digs[i] != 0) msd = i;
        end
        for (int i = 0; i < 6; i++) begin
            r[7*i +: 7] = (i > msd) ? 7'h7F : seg_of(digs[i]);
        end
        return r;
    endfunction

    task automatic push_exp(input logic [41:0] h, input logic [17:0] l, input int len);
        exp_t e;
        e.hex  = h;
        e.leds = l;
        e.len  = len;
        sb.push_back(e);
        n_pushed++;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (haltOut !== 1'b0 && t < 100) begin
            @(posedge clock);
            #1;
            t++;
        end
        if (t >= 100) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_idle: haltOut=%b still after %0d cycles, required 0", haltOut, t);
        end
    endtask

    task automatic issue(input int v);
        wait_idle();
        dado          = v[17:0];
        escreveOutput = 1'b1;
        push_exp(model_hex(v), v[17:0], 19);
        @(posedge clock);
        #1;
        escreveOutput = 1'b0;
    endtask

    // Monitor: tracks each haltOut window and checks the display when it closes.
    initial begin
        wait (mon_en);
        forever begin
            @(negedge clock);
            if (haltOut === 1'b1) begin
                if (m_prev !== 1'b1) begin
                    m_pre_hex  = hex;
                    m_pre_leds = leds;
                    m_len      = 0;
                    m_stable   = 1'b1;
                end
                m_len++;
                if (hex !== m_pre_hex || leds !== m_pre_leds) m_stable = 1'b0;
            end else if (m_prev === 1'b1) begin
                check("hold_during_convert", 64'(m_stable), 64'd1);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_conversion: got hex=%0h leds=%0h with nothing queued", hex, leds);
                end else begin
                    m_e = sb.pop_front();
                    check("halt_cycles", 64'(m_len), 64'(m_e.len));
                    check("hex", 64'(hex), 64'(m_e.hex));
                    check("leds", 64'(leds), 64'(m_e.leds));
                    n_conv++;
                end
            end
            m_prev = haltOut;
        end
    end

    initial begin
        int v;
        reset         = 1'b1;
        escreveOutput = 1'b0;
        dado          = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset_hex", 64'(hex), 64'(ALL_BLANK));
        check("reset_leds", 64'(leds), 64'd0);
        check("reset_halt", 64'(haltOut), 64'd0);
        mon_en = 1'b1;

        repeat (10) @(posedge clock);
        #1;
        check("idle_hex", 64'(hex), 64'(ALL_BLANK));
        check("idle_halt", 64'(haltOut), 64'd0);

        issue(0);
        issue(12345);
        wait_idle();
        check("hex_12345", 64'(hex), 64'({7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12}));
        issue(262143);
        wait_idle();
        check("hex_max", 64'(hex), 64'({7'h24, 7'h02, 7'h24, 7'h79, 7'h19, 7'h30}));

        // Second write during conversion must be dropped.
        issue(7);
        repeat (4) @(posedge clock);
        #1;
        dado          = 18'd9;
        escreveOutput = 1'b1;
        @(posedge clock);
        #1;
        escreveOutput = 1'b0;
        wait_idle();
        check("hex0_ignored", 64'(hex[6:0]), 64'(7'h78));

        // Reset ten cycles into a conversion.
        wait_idle();
        dado          = 18'd999;
        escreveOutput = 1'b1;
        push_exp(ALL_BLANK, 18'd0, 10);
        @(posedge clock);
        #1;
        escreveOutput = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("abort_halt", 64'(haltOut), 64'd0);
        check("abort_hex", 64'(hex), 64'(ALL_BLANK));

        issue(42);
        wait_idle();
        check("hex_42", 64'(hex[13:0]), 64'({7'h19, 7'h24}));

        // A flag held high re-triggers on every IDLE cycle.
        wait_idle();
        v = $urandom_range(0, 262143);
        dado          = v[17:0];
        escreveOutput = 1'b1;
        for (int k = 0; k < 3; k++) push_exp(model_hex(v), v[17:0], 19);
        repeat (45) @(posedge clock);
        #1;
        escreveOutput = 1'b0;

        for (int k = 0; k < 20; k++) begin
            v = (k % 2 == 1) ? $urandom_range(0, 262143) : $urandom_range(0, 999);
            issue(v);
        end

        wait_idle();
        repeat (3) @(posedge clock);
        #1;
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        check("conversion_count", 64'(n_conv), 64'(n_pushed));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
